schematic: RTL and testbench

- Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
- An active-low push-button input `b0` starts one transfer.
- Transmits `in_data` on `MOSI`, samples `MISO`, and presents the received byte on `RM`.
- Sits between board-level button/switch inputs and an external SPI slave.

---
 rtl/schematic_if.sv | 22 ++
 rtl/schematic.sv | 167 ++++++++++++++++
 tb/tb_schematic.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/schematic_if.sv
// SPI bus between the schematic master and an external slave.
// The master drives CS, clkSeq and MOSI; the slave drives MISO.
interface schematic_if;
    logic CS;
    logic clkSeq;
    logic MOSI;
    logic MISO;

    modport master (
        output CS,
        output clkSeq,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  CS,
        input  clkSeq,
        input  MOSI,
        output MISO
    );
endinterface

// File: rtl/schematic.sv
// Single-byte SPI master (mode 0, MSB first) started by an active-low push button.
// Define DEBOUNCE_EN to require DEBOUNCE_CYCLES stable samples of b0 before a start.
module schematic #(
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              b0,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] RM,
    schematic_if.master       bus
);

    localparam int unsigned BitW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                start;
    logic [7:0]          div_q, div_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rm_q, rm_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;

`ifdef DEBOUNCE_EN
    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

    logic           db_q, db_d;
    logic [DbW-1:0] dbc_q, dbc_d;

    // db_q is the debounced button level; it flips only after the synchronized input has
    // disagreed with it long enough, and a press fires on its high-to-low flip.
    always_comb begin
        db_d  = db_q;
        dbc_d = '0;
        start = 1'b0;
        if (sync2_q != db_q) begin
            if (dbc_q == DbW'(DEBOUNCE_CYCLES)) begin
                db_d  = sync2_q;
                start = db_q;
            end else begin
                dbc_d = dbc_q + DbW'(1);
            end
        end
    end
`else
    logic edge_q, edge_d;

    always_comb begin
        edge_d = sync2_q;
        start  = edge_q & ~sync2_q;
    end
`endif

    always_comb begin
        sync1_d = b0;
        sync2_d = sync1_q;
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rm_d    = rm_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;

        unique case (state_q)
            StIdle: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                div_d  = '0;
                bit_d  = '0;
                if (start) begin
                    tx_d    = in_data;
                    rx_d    = '0;
                    cs_d    = 1'b0;
                    mosi_d  = in_data[DATA_W-1];
                    state_d = StShift;
                end
            end
            StShift: begin
                if (div_q == 8'(CLK_DIV - 1)) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d  = {rx_q[DATA_W-2:0], bus.MISO};
                        bit_d = bit_q + BitW'(1);
                    end else if (bit_q != BitW'(DATA_W)) begin
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[DATA_W-2];
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
                // Leave one cycle early so DONE lands on the final clkSeq fall.
                if (sclk_q && bit_q == BitW'(DATA_W) && div_q == 8'(CLK_DIV - 2)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                rm_d    = rx_q;
                div_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
`ifdef DEBOUNCE_EN
            db_q    <= 1'b1;
            dbc_q   <= '0;
`else
            edge_q  <= 1'b1;
`endif
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rm_q    <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
`ifdef DEBOUNCE_EN
            db_q    <= db_d;
            dbc_q   <= dbc_d;
`else
            edge_q  <= edge_d;
`endif
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rm_q    <= rm_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    assign bus.CS     = cs_q;
    assign bus.clkSeq = sclk_q;
    assign bus.MOSI   = mosi_q;
    assign RM         = rm_q;

endmodule

// File: tb/tb_schematic.sv
// Directed bench for the schematic SPI master: reset, frames, single-shot, loopback, abort.
module tb_schematic;

`ifdef DEBOUNCE_EN
    localparam int unsigned Lat = 1003;
    localparam int unsigned Rel = 1100;
`else
    localparam int unsigned Lat = 3;
    localparam int unsigned Rel = 10;
`endif
    localparam int unsigned CsLow = 64;

    logic       clk;
    logic       rst_n;
    logic       b0;
    logic [7:0] in_data;
    logic [7:0] RM;
    logic       miso_drv;
    logic       loop_en;

    int n_tests = 0;
    int n_fail  = 0;

    schematic_if spi_bus ();

    assign spi_bus.MISO = loop_en ? spi_bus.MOSI : miso_drv;

    schematic #(
        .CLK_DIV        (4),
        .DATA_W         (8),
        .DEBOUNCE_CYCLES(1000)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .b0     (b0),
        .in_data(in_data),
        .RM     (RM),
        .bus    (spi_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Count cycles in which CS is low over a window, for "nothing happens" checks.
    task automatic watch_idle(input int cycles, output int act);
        act = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (spi_bus.CS !== 1'b1 || spi_bus.clkSeq !== 1'b0) act++;
        end
    endtask

    // Press b0 and follow one frame; b0 is left held low on return.
    task automatic do_frame(input string tag, input logic [7:0] data, input logic miso_v,
                            input logic loop_v, input logic [7:0] late_data,
                            input logic [7:0] exp_rm);
        int         lat;
        int         cs_low;
        int         pulses;
        logic [7:0] bits;
        logic       prev_sclk;
        @(negedge clk);
        in_data  = data;
        miso_drv = miso_v;
        loop_en  = loop_v;
        b0       = 1'b0;
        lat      = 0;
        while (lat < Lat + 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (spi_bus.CS === 1'b0) break;
        end
        check_eq({tag, "_cs_latency"}, lat, Lat);
        in_data   = late_data;
        cs_low    = 1;
        pulses    = 0;
        bits      = '0;
        prev_sclk = spi_bus.clkSeq;
        while (cs_low < 200) begin
            @(posedge clk);
            #1;
            if (spi_bus.CS !== 1'b0) break;
            cs_low++;
            if (spi_bus.clkSeq === 1'b1 && prev_sclk === 1'b0) begin
                pulses++;
                bits = {bits[6:0], spi_bus.MOSI};
            end
            prev_sclk = spi_bus.clkSeq;
        end
        check_eq({tag, "_cs_low"}, cs_low, CsLow);
        check_eq({tag, "_pulses"}, pulses, 8);
        check_eq({tag, "_mosi_bits"}, bits, data);
        check_eq({tag, "_sclk_end"}, spi_bus.clkSeq, 1'b0);
        check_eq({tag, "_rm"}, RM, exp_rm);
        loop_en = 1'b0;
    endtask

    task automatic release_b0();
        @(negedge clk);
        b0 = 1'b1;
        repeat (Rel) @(posedge clk);
    endtask

    initial begin
        int act;
        int pulses;
        int guard;
        logic prev_sclk;

        rst_n    = 1'b0;
        b0       = 1'b1;
        in_data  = 8'h00;
        miso_drv = 1'b0;
        loop_en  = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_cs", spi_bus.CS, 1'b1);
        check_eq("rst_sclk", spi_bus.clkSeq, 1'b0);
        check_eq("rst_mosi", spi_bus.MOSI, 1'b0);
        check_eq("rst_rm", RM, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

`ifdef DEBOUNCE_EN
        @(negedge clk);
        b0 = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        b0 = 1'b1;
        watch_idle(1500, act);
        check_eq("glitch_no_frame", act, 0);
`endif

        // Basic frame; in_data changed after start must not affect it.
        do_frame("basic", 8'hAA, 1'b1, 1'b0, 8'h00, 8'hFF);

        watch_idle(3000, act);
        check_eq("single_shot_idle", act, 0);
        check_eq("single_shot_rm", RM, 8'hFF);
        check_eq("idle_mosi", spi_bus.MOSI, 1'b0);

        release_b0();
        do_frame("second", 8'h3C, 1'b0, 1'b0, 8'hFF, 8'h00);

        release_b0();
        do_frame("loop", 8'h5A, 1'b0, 1'b1, 8'h00, 8'h5A);

        // Abort after the third clkSeq rising edge.
        release_b0();
        @(negedge clk);
        in_data  = 8'hAA;
        miso_drv = 1'b1;
        b0       = 1'b0;
        pulses    = 0;
        guard     = 0;
        prev_sclk = 1'b0;
        while (pulses < 3 && guard < Lat + 200) begin
            @(posedge clk);
            #1;
            guard++;
            if (spi_bus.clkSeq === 1'b1 && prev_sclk === 1'b0) pulses++;
            prev_sclk = spi_bus.clkSeq;
        end
        check_eq("abort_reach_pulse3", pulses, 3);
        @(negedge clk);
        rst_n = 1'b0;
        b0    = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_cs", spi_bus.CS, 1'b1);
        check_eq("abort_sclk", spi_bus.clkSeq, 1'b0);
        check_eq("abort_mosi", spi_bus.MOSI, 1'b0);
        check_eq("abort_rm", RM, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        watch_idle(Rel + 300, act);
        check_eq("abort_no_frame", act, 0);
        check_eq("abort_rm_held", RM, 8'h00);

        do_frame("recover", 8'h81, 1'b1, 1'b0, 8'h7E, 8'hFF);
        release_b0();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
